// File: rtl/bcd_addsub_serial_if.sv
// Request/result bundle for the digit-serial BCD adder/subtractor.
// The master drives Start/Mode/A/B; the slave returns status and result.
interface bcd_addsub_serial_if #(
  parameter int DIGITS = 4
);
  logic                  Start;
  logic                  Mode;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  Busy;
  logic                  Done;
  logic [4*DIGITS-1:0]   Result;
  logic                  Carry_Out;
  logic                  Negative;
  logic                  Invalid;

  modport master (
    output Start, Mode, A, B,
    input  Busy, Done, Result, Carry_Out, Negative, Invalid
  );

  modport slave (
    input  Start, Mode, A, B,
    output Busy, Done, Result, Carry_Out, Negative, Invalid
  );
endinterface

// File: rtl/bcd_addsub_serial.sv
// Digit-serial N-digit BCD adder/subtractor, sign-magnitude result via a recomplement pass.
// Optional non-BCD input detection is enabled by defining BCD_INVALID_DETECT_EN.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input logic               Clk,
  input logic               Reset,
  bcd_addsub_serial_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_EVAL     = CW'(DIGITS);
  localparam logic [CW-1:0] CNT_FIX_LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   a_sh_reg, a_sh_next;
  logic [W-1:0]   b_sh_reg, b_sh_next;
  logic [W-1:0]   sum_reg, sum_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           carry_reg, carry_next;
  logic           mode_reg, mode_next;
  logic           err_reg, err_next;
  logic [W-1:0]   result_reg, result_next;
  logic           cout_reg, cout_next;
  logic           neg_reg, neg_next;
  logic           inv_reg, inv_next;

  logic [3:0]     add_x, add_y, add_digit;
  logic [4:0]     add_s;
  logic           add_carry;
  logic [W+3:0]   sum_shift;
  logic           digit_bad;

`ifdef BCD_INVALID_DETECT_EN
  assign digit_bad = (a_sh_reg[3:0] > 4'd9) || (b_sh_reg[3:0] > 4'd9);
`else
  assign digit_bad = 1'b0;
`endif

  // Shared single-digit BCD adder; FIX reuses it to ten's-complement the sum.
  always_comb begin
    add_x = a_sh_reg[3:0];
    add_y = mode_reg ? (4'd9 - b_sh_reg[3:0]) : b_sh_reg[3:0];
    if (state_reg == FIX) begin
      add_x = 4'd9 - sum_reg[3:0];
      add_y = 4'd0;
    end
    add_s = {1'b0, add_x} + {1'b0, add_y} + {4'd0, carry_reg};
    if (add_s > 5'd9) begin
      add_digit = 4'(add_s + 5'd6);
      add_carry = 1'b1;
    end else begin
      add_digit = add_s[3:0];
      add_carry = 1'b0;
    end
  end

  // New digit enters at the top so digit 0 ends up in bits [3:0].
  assign sum_shift = {add_digit, sum_reg};

  always_comb begin
    state_next  = state_reg;
    a_sh_next   = a_sh_reg;
    b_sh_next   = b_sh_reg;
    sum_next    = sum_reg;
    cnt_next    = cnt_reg;
    carry_next  = carry_reg;
    mode_next   = mode_reg;
    err_next    = err_reg;
    result_next = result_reg;
    cout_next   = cout_reg;
    neg_next    = neg_reg;
    inv_next    = inv_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.Start) begin
          a_sh_next  = bus.A;
          b_sh_next  = bus.B;
          mode_next  = bus.Mode;
          carry_next = bus.Mode;
          sum_next   = '0;
          cnt_next   = '0;
          err_next   = 1'b0;
          state_next = ADD;
        end else begin
          state_next = IDLE;
        end
      end
      ADD: begin
        if (cnt_reg != CNT_EVAL) begin
          a_sh_next  = a_sh_reg >> 4;
          b_sh_next  = b_sh_reg >> 4;
          sum_next   = sum_shift[W+3:4];
          carry_next = add_carry;
          err_next   = err_reg | digit_bad;
          cnt_next   = cnt_reg + 1'b1;
        end else if (mode_reg && !carry_reg && !err_reg) begin
          // No end-around carry: A < B, so recomplement the sum.
          carry_next = 1'b1;
          cnt_next   = '0;
          state_next = FIX;
        end else begin
          result_next = err_reg ? '0 : sum_reg;
          cout_next   = !mode_reg && !err_reg && carry_reg;
          neg_next    = 1'b0;
          inv_next    = err_reg;
          state_next  = DONE;
        end
      end
      FIX: begin
        sum_next   = sum_shift[W+3:4];
        carry_next = add_carry;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CNT_FIX_LAST) begin
          result_next = sum_shift[W+3:4];
          cout_next   = 1'b0;
          neg_next    = 1'b1;
          inv_next    = 1'b0;
          state_next  = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_reg    <= '0;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      mode_reg   <= 1'b0;
      err_reg    <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      inv_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_sh_reg   <= a_sh_next;
      b_sh_reg   <= b_sh_next;
      sum_reg    <= sum_next;
      cnt_reg    <= cnt_next;
      carry_reg  <= carry_next;
      mode_reg   <= mode_next;
      err_reg    <= err_next;
      result_reg <= result_next;
      cout_reg   <= cout_next;
      neg_reg    <= neg_next;
      inv_reg    <= inv_next;
    end
  end

  assign bus.Busy      = (state_reg == ADD) || (state_reg == FIX);
  assign bus.Done      = (state_reg == DONE);
  assign bus.Result    = result_reg;
  assign bus.Carry_Out = cout_reg;
  assign bus.Negative  = neg_reg;
  assign bus.Invalid   = inv_reg;
endmodule
